// File: rtl/simple_i2c_slave_if.sv
// Pin-side and local-side signals of the simple I2C target.
// The slave modport is the endpoint view. The master modport is the view of whatever drives the pins and serves reads.
interface simple_i2c_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [6:0] own_addr_i;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       rd_req_o;
  logic [7:0] rd_data_i;
  logic       busy_o;
  logic       tra_o;

  modport slave (
    input  scl_i, sda_i, own_addr_i, rd_data_i,
    output sda_oe_o, wr_data_o, wr_valid_o, rd_req_o, busy_o, tra_o
  );

  modport master (
    output scl_i, sda_i, own_addr_i, rd_data_i,
    input  sda_oe_o, wr_data_o, wr_valid_o, rd_req_o, busy_o, tra_o
  );
endinterface

// File: rtl/simple_i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, and 7-bit address match.
// Each write byte is delivered as a one-cycle pulse; each read byte is fetched with a one-cycle request.
module simple_i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic               clk_i,
  input logic               srst_n_i,
  simple_i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_hist, sda_hist;
  logic                   scl_s, sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // NOTE: synchronizer and history flops only follow the pins, so they carry no reset;
  // the strobe register below is the first stage that is cleared.
  always_ff @(posedge clk_i) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
    scl_hist <= scl_s;
    sda_hist <= sda_s;
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  // Strobes are registered, so each one lags the pin by SYNC_STAGES+1 cycles.
  // SDA edges count as START/STOP only while SCL is high in both samples.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b0;
    end else begin
      scl_rise  <= scl_s & ~scl_hist;
      scl_fall  <= ~scl_s & scl_hist;
      start_det <= scl_s & scl_hist & sda_hist & ~sda_s;
      stop_det  <= scl_s & scl_hist & ~sda_hist & sda_s;
      sda_bit   <= sda_s;
    end
  end

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] wr_data, wr_data_n;
  logic [7:0] rx_byte;
  logic       sda_oe, sda_oe_n;
  logic       wr_valid, wr_valid_n;
  logic       rd_req, rd_req_n;
  logic       busy, busy_n;
  logic       tra, tra_n;

  assign rx_byte = {shreg[6:0], sda_bit};

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      wr_data  <= 8'h00;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      tra      <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      wr_data  <= wr_data_n;
      sda_oe   <= sda_oe_n;
      wr_valid <= wr_valid_n;
      rd_req   <= rd_req_n;
      busy     <= busy_n;
      tra      <= tra_n;
    end
  end

  always_comb begin
    // NOTE: every next-state value is given a hold/idle default first, so no path leaves one unassigned.
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    wr_data_n  = wr_data;
    sda_oe_n   = sda_oe;
    wr_valid_n = 1'b0;
    rd_req_n   = 1'b0;
    busy_n     = busy;
    tra_n      = tra;

    if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      tra_n     = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == bus.own_addr_i) begin
                state_n = ADDR_ACK;
                tra_n   = rx_byte[0];
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT;
                busy_n  = 1'b0;
                tra_n   = 1'b0;
              end
            end
          end
        end

        // The first fall drives the ACK low; the second fall ends the ACK bit.
        ADDR_ACK, WR_ACK: begin
          if (scl_rise && state == ADDR_ACK && tra) begin
            rd_req_n = 1'b1;
          end
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (state == ADDR_ACK && tra) begin
              shreg_n   = bus.rd_data_i;
              sda_oe_n  = ~bus.rd_data_i[7];
              bit_cnt_n = 3'd0;
              state_n   = RD_DATA;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_data_n  = rx_byte;
              wr_valid_n = 1'b1;
              state_n    = WR_ACK;
            end
          end
        end

        // The MSB was already driven at load time, so seven falls shift out the rest.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              sda_oe_n  = ~shreg[6];
              shreg_n   = {shreg[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_bit) begin
              rd_req_n = 1'b1;
            end else begin
              state_n = WAIT;
              busy_n  = 1'b0;
            end
          end
          if (scl_fall) begin
            shreg_n   = bus.rd_data_i;
            sda_oe_n  = ~bus.rd_data_i[7];
            bit_cnt_n = 3'd0;
            state_n   = RD_DATA;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.sda_oe_o   = sda_oe;
  assign bus.wr_data_o  = wr_data;
  assign bus.wr_valid_o = wr_valid;
  assign bus.rd_req_o   = rd_req;
  assign bus.busy_o     = busy;
  assign bus.tra_o      = tra;

endmodule

// File: tb/tb_simple_i2c_slave.sv
// Bench for simple_i2c_slave. A bit-level I2C master drives the pins, and a transaction model predicts ACKs, read bits,
// busy/tra and write bytes. One process compares those predictions with the DUT every cycle.
module tb_simple_i2c_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic [6:0] own_addr = 7'h50;

  always #5 clk = ~clk;

  simple_i2c_slave_if bus ();
  assign bus.scl_i      = m_scl;
  assign bus.sda_i      = m_sda & ~bus.sda_oe_o;
  assign bus.rd_data_i  = rd_data;
  assign bus.own_addr_i = own_addr;

  simple_i2c_slave #(.SYNC_STAGES(2)) dut (
    .clk_i    (clk),
    .srst_n_i (srst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model state. It is written only by the stimulus process.
  logic exp_oe = 1'b0, exp_busy = 1'b0, exp_tra = 1'b0;
  logic addressed = 1'b0;
  logic chk_en = 1'b0;
  int   settle_t = 0;
  logic [7:0] wr_exp_q [16];
  int   wr_exp_n = 0;
  int   exp_rd_cnt = 0;
  logic [7:0] rd_src [8];

  // Observed state. It is written only by the compare and responder processes.
  int   cyc = 0;
  logic [7:0] wr_log [16];
  int   wr_got_n = 0;
  int   rd_req_cnt = 0;
  int   oe_hits = 0;
  logic wv_prev = 1'b0, rq_prev = 1'b0;
  logic rq_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.sda_oe_o) oe_hits++;
    if (chk_en) begin
      if (cyc >= settle_t) begin
        check("sda_oe", {31'd0, bus.sda_oe_o}, {31'd0, exp_oe});
        check("busy", {31'd0, bus.busy_o}, {31'd0, exp_busy});
        check("tra", {31'd0, bus.tra_o}, {31'd0, exp_tra});
      end
      if (bus.wr_valid_o) begin
        check("wr_valid_width", {31'd0, wv_prev}, 32'd0);
        if (wr_got_n < wr_exp_n)
          check("wr_data", {24'd0, bus.wr_data_o}, {24'd0, wr_exp_q[wr_got_n]});
        else
          check("wr_valid_unexpected", {31'd0, bus.wr_valid_o}, 32'd0);
        if (wr_got_n < 16) wr_log[wr_got_n] = bus.wr_data_o;
        wr_got_n++;
      end
      if (bus.rd_req_o) check("rd_req_width", {31'd0, rq_prev}, 32'd0);
    end
    wv_prev = bus.wr_valid_o;
    rq_prev = bus.rd_req_o;
  end

  // Local read responder. It presents the next source byte one cycle after it sees each request.
  always @(negedge clk) begin
    if (rq_seen) begin
      rd_data = rd_src[(rd_req_cnt - 1) % 8];
      rq_seen = 1'b0;
    end
    if (bus.rd_req_o) begin
      rd_req_cnt++;
      rq_seen = 1'b1;
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_exp(input logic oe, input logic b, input logic t);
    exp_oe   = oe;
    exp_busy = b;
    exp_tra  = t;
    settle_t = cyc + 8;
  endtask

  // One SCL clock. It starts at the falling edge.
  // drv is what the slave must drive for this bit; nb/nt are busy/tra after the rising edge.
  task automatic bit_xfer(input logic mb, input logic drv, input logic nb, input logic nt, output logic s);
    m_scl = 1'b0;
    set_exp(drv, exp_busy, exp_tra);
    clocks(Q);
    m_sda = mb;
    clocks(Q);
    m_scl = 1'b1;
    set_exp(exp_oe, nb, nt);
    clocks(Q);
    s = bus.sda_i;
    clocks(Q);
  endtask

  task automatic i2c_start();
    m_scl = 1'b0;
    set_exp(1'b0, exp_busy, exp_tra);
    clocks(Q);
    m_sda = 1'b1;
    clocks(Q);
    m_scl = 1'b1;
    clocks(Q);
    m_sda = 1'b0;
    clocks(Q);
  endtask

  task automatic i2c_stop();
    m_scl = 1'b0;
    set_exp(1'b0, exp_busy, exp_tra);
    clocks(Q);
    m_sda = 1'b0;
    clocks(Q);
    m_scl = 1'b1;
    clocks(Q);
    m_sda = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    addressed = 1'b0;
    clocks(2 * Q);
  endtask

  task automatic send_addr(input logic [7:0] a);
    logic match, s;
    match = (a[7:1] == own_addr);
    for (int i = 7; i >= 1; i--) bit_xfer(a[i], 1'b0, exp_busy, exp_tra, s);
    bit_xfer(a[0], 1'b0, match, match & a[0], s);
    bit_xfer(1'b1, match, exp_busy, exp_tra, s);
    check("addr_ack_level", {31'd0, s}, {31'd0, ~match});
    addressed = match;
    if (match && a[0]) exp_rd_cnt++;
  endtask

  task automatic send_data(input logic [7:0] d);
    logic s;
    if (addressed) begin
      wr_exp_q[wr_exp_n % 16] = d;
      wr_exp_n++;
    end
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], 1'b0, exp_busy, exp_tra, s);
    bit_xfer(1'b1, addressed, exp_busy, exp_tra, s);
    check("data_ack_level", {31'd0, s}, {31'd0, ~addressed});
  endtask

  task automatic recv_data(input logic [7:0] e, input logic ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, ~e[i], exp_busy, exp_tra, s);
      got[i] = s;
    end
    bit_xfer(~ack, 1'b0, ack & exp_busy, exp_tra, s);
    if (ack) exp_rd_cnt++;
    check("rd_byte_model", {24'd0, got}, {24'd0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s;
    logic [7:0] got;
    int oe_before;
    rd_src[0] = 8'hC3;
    rd_src[1] = 8'h5A;
    rd_src[2] = 8'h96;
    rd_src[3] = 8'h3C;
    for (int i = 4; i < 8; i++) rd_src[i] = 8'hFF;

    // Reset values
    clocks(6);
    check("rst_sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("rst_wr_data", {24'd0, bus.wr_data_o}, 32'd0);
    check("rst_wr_valid", {31'd0, bus.wr_valid_o}, 32'd0);
    check("rst_rd_req", {31'd0, bus.rd_req_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_tra", {31'd0, bus.tra_o}, 32'd0);
    srst_n = 1'b1;
    clocks(4);
    chk_en = 1'b1;

    // Write: 0xA0, 0xA5, 0x3C
    i2c_start();
    send_addr(8'hA0);
    check("wr_busy_after_addr", {31'd0, bus.busy_o}, 32'd1);
    send_data(8'hA5);
    send_data(8'h3C);
    i2c_stop();
    check("wr_count", wr_got_n, 32'd2);
    check("wr_first", {24'd0, wr_log[0]}, 32'hA5);
    check("wr_second", {24'd0, wr_log[1]}, 32'h3C);
    check("wr_busy_after_stop", {31'd0, bus.busy_o}, 32'd0);

    // Address mismatch
    oe_before = oe_hits;
    i2c_start();
    send_addr(8'hA2);
    send_data(8'h11);
    i2c_stop();
    check("mm_oe_never", oe_hits - oe_before, 32'd0);
    check("mm_wr_count", wr_got_n, 32'd2);

    // Read: 0xC3 with ACK, 0x5A with NACK, then an ignored clock in WAIT
    i2c_start();
    send_addr(8'hA1);
    check("rd_tra", {31'd0, bus.tra_o}, 32'd1);
    recv_data(8'hC3, 1'b1, got);
    check("rd_byte0", {24'd0, got}, 32'hC3);
    recv_data(8'h5A, 1'b0, got);
    check("rd_byte1", {24'd0, got}, 32'h5A);
    check("rd_busy_after_nack", {31'd0, bus.busy_o}, 32'd0);
    bit_xfer(1'b1, 1'b0, 1'b0, 1'b1, s);
    check("wait_release", {31'd0, s}, 32'd1);
    i2c_stop();
    check("rd_req_count", rd_req_cnt, 32'd2);
    check("rd_tra_after_stop", {31'd0, bus.tra_o}, 32'd0);

    // Repeated START: write 0x07, then read one byte
    i2c_start();
    send_addr(8'hA0);
    send_data(8'h07);
    check("rs_tra_write", {31'd0, bus.tra_o}, 32'd0);
    i2c_start();
    send_addr(8'hA1);
    check("rs_tra_read", {31'd0, bus.tra_o}, 32'd1);
    recv_data(8'h96, 1'b0, got);
    check("rs_rd_byte", {24'd0, got}, 32'h96);
    i2c_stop();
    check("rs_wr_count", wr_got_n, 32'd3);
    check("rs_wr_byte", {24'd0, wr_log[2]}, 32'h07);
    check("rs_rd_req_count", rd_req_cnt, 32'd3);

    // STOP in the middle of a write byte
    i2c_start();
    send_addr(8'hA0);
    bit_xfer(1'b1, 1'b0, exp_busy, exp_tra, s);
    bit_xfer(1'b0, 1'b0, exp_busy, exp_tra, s);
    bit_xfer(1'b1, 1'b0, exp_busy, exp_tra, s);
    bit_xfer(1'b0, 1'b0, exp_busy, exp_tra, s);
    i2c_stop();
    check("mid_wr_count", wr_got_n, 32'd3);
    check("mid_sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("mid_busy", {31'd0, bus.busy_o}, 32'd0);

    // Reset while the slave drives a 0 read bit (0x3C has MSB 0)
    i2c_start();
    send_addr(8'hA1);
    m_scl = 1'b0;
    set_exp(1'b1, exp_busy, exp_tra);
    clocks(8);
    check("rst_pre_drive", {31'd0, bus.sda_oe_o}, 32'd1);
    chk_en = 1'b0;
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
    check("mrst_wr_data", {24'd0, bus.wr_data_o}, 32'd0);
    check("mrst_wr_valid", {31'd0, bus.wr_valid_o}, 32'd0);
    check("mrst_rd_req", {31'd0, bus.rd_req_o}, 32'd0);
    check("mrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("mrst_tra", {31'd0, bus.tra_o}, 32'd0);
    clocks(2);
    m_sda = 1'b1;
    m_scl = 1'b1;
    clocks(6);
    srst_n = 1'b1;
    addressed = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    clocks(4);
    chk_en = 1'b1;
    i2c_start();
    send_addr(8'hA0);
    send_data(8'h99);
    i2c_stop();
    check("post_rst_wr_count", wr_got_n, 32'd4);
    check("post_rst_wr_byte", {24'd0, wr_log[3]}, 32'h99);
    check("rd_req_total_literal", rd_req_cnt, 32'd4);

    check("rd_req_total", rd_req_cnt, exp_rd_cnt);
    check("wr_total", wr_got_n, wr_exp_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
